// File: rtl/mfp_uart_pkg.sv
// Shared definitions for the MFP UART transmitter: FSM encoding and frame constants.
package mfp_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 217;
  localparam int FRAME_BITS           = 10;
  localparam int DATA_BITS            = 8;

endpackage

// File: rtl/mfp_uart_tx_fifo.sv
// Synchronous byte FIFO feeding the UART transmitter; head byte is visible combinationally.
module mfp_uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [7:0]             push_data,
  input  logic                   pop,
  output logic [7:0]             head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  // A push while full is dropped even when a pop lands in the same cycle.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so pointer overflow gives the modulo wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mfp_uart_transmitter.sv
// 8N1 UART transmitter with a small byte FIFO; back-to-back frames leave no idle gap.
module mfp_uart_transmitter
  import mfp_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_valid,
  input  logic [7:0]                  wr_data,
  output logic                        wr_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        busy,
  output logic                        UART_TX
);

  localparam int              CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      BIT_LAST  = 3'(DATA_BITS - 1);

  uart_state_t   state;
  uart_state_t   state_next;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic          tx_q;
  logic          tx_next;
  logic          baud_last;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_head;

  mfp_uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_valid),
    .push_data (wr_data),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign baud_last = (baud_cnt == BAUD_LAST);
  assign wr_ready  = !fifo_full;
  assign busy      = (state != IDLE) || (fifo_count != '0);
  assign UART_TX   = tx_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (!fifo_empty) state_next = START;
      START: if (baud_last) state_next = DATA;
      DATA:  if (baud_last && (bit_idx == BIT_LAST)) state_next = STOP;
      STOP:  if (baud_last) state_next = fifo_empty ? IDLE : START;
      default: state_next = IDLE;
    endcase
  end

  // The line value is registered from the current state, so it trails the FSM by one cycle.
  always_comb begin
    tx_next  = 1'b1;
    fifo_pop = 1'b0;
    case (state)
      IDLE: begin
        tx_next  = 1'b1;
        fifo_pop = !fifo_empty;
      end
      START: tx_next = 1'b0;
      DATA:  tx_next = shift_reg[0];
      STOP: begin
        tx_next  = 1'b1;
        fifo_pop = baud_last && !fifo_empty;
      end
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      tx_q      <= 1'b1;
    end else begin
      tx_q <= tx_next;
      if ((state == IDLE) || baud_last) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + CW'(1);
      end
      if (fifo_pop) begin
        shift_reg <= fifo_head;
      end else if ((state == DATA) && baud_last) begin
        shift_reg <= {1'b0, shift_reg[7:1]};
      end
      if (state != DATA) begin
        bit_idx <= '0;
      end else if (baud_last) begin
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

endmodule
